// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states,
// instruction classes, sign-extension / ALU / write-back / next-PC codes
// and RV32I opcode constants.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_OP, CLS_OPIMM, CLS_LOAD, CLS_STORE, CLS_JAL,
    CLS_JALR, CLS_BRANCH, CLS_LUI, CLS_ILL
  } ctrl_class_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] EXT_NONE  = 3'd0;
  localparam logic [2:0] EXT_I     = 3'd1;
  localparam logic [2:0] EXT_S     = 3'd2;
  localparam logic [2:0] EXT_B     = 3'd3;
  localparam logic [2:0] EXT_U     = 3'd4;
  localparam logic [2:0] EXT_J     = 3'd5;
  localparam logic [2:0] EXT_SHIFT = 3'd6;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JAL  = 2'd2;
  localparam logic [1:0] NPC_JALR = 2'd3;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  // funct3 -> ALU op; SUB only exists for register-register ops
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                             input logic is_reg);
    case (f3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decode: ir -> class, legality and the
// datapath selects that stay constant for the life of an instruction.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output ctrl_class_e  cls,
  output logic         legal,
  output logic [2:0]   sext_op,
  output logic [3:0]   alu_op,
  output logic         alub_sel,
  output logic [1:0]   wb_sel
);

  logic [2:0] funct3;
  assign funct3 = ir[14:12];

  // classify opcode and derive the per-instruction selects
  always_comb begin
    cls      = CLS_ILL;
    legal    = 1'b0;
    sext_op  = EXT_NONE;
    alu_op   = ALU_ADD;
    alub_sel = 1'b0;
    wb_sel   = WB_ALU;
    case (ir[6:0])
      OPC_LUI: begin
        cls = CLS_LUI; legal = 1'b1; sext_op = EXT_U; alub_sel = 1'b1; wb_sel = WB_IMM;
      end
      OPC_OP: begin
        cls = CLS_OP; legal = 1'b1; alu_op = alu_from_f3(funct3, ir[30], 1'b1);
      end
      OPC_OPIMM: begin
        cls      = CLS_OPIMM;
        legal    = 1'b1;
        sext_op  = (funct3 == 3'b001 || funct3 == 3'b101) ? EXT_SHIFT : EXT_I;
        alu_op   = alu_from_f3(funct3, ir[30], 1'b0);
        alub_sel = 1'b1;
      end
      OPC_LOAD: begin
        cls = CLS_LOAD; legal = (funct3 == 3'b010); sext_op = EXT_I;
        alub_sel = 1'b1; wb_sel = WB_MEM;
      end
      OPC_STORE: begin
        cls = CLS_STORE; legal = (funct3 == 3'b010); sext_op = EXT_S; alub_sel = 1'b1;
      end
      OPC_JAL: begin
        cls = CLS_JAL; legal = 1'b1; sext_op = EXT_J; wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        cls = CLS_JALR; legal = 1'b1; sext_op = EXT_I; alub_sel = 1'b1; wb_sel = WB_PC4;
      end
      OPC_BRANCH: begin
        cls     = CLS_BRANCH;
        legal   = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
        sext_op = EXT_B;
        alu_op  = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller for the RV32I core: fetch handshake, IR,
// per-instruction sequencing and all datapath strobes.
// Optional macro CTRL_TIMEOUT_EN bounds bus waits at TIMEOUT_CYC cycles
// and traps with bus_err; without it waits are unbounded and bus_err=0.
//
//   state  | meaning
//   FETCH  | ireq held until iack, IR loads on the iack cycle
//   DECODE | classify IR, illegal encodings go to TRAP
//   EXEC   | jumps/branches retire here, others move on
//   MEM    | dreq held until dack; sw retires on dack
//   WB     | register write and PC+4 update
//   TRAP   | all strobes off, left only by reset
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst_n,
  output logic        ireq,
  input  logic        iack,
  input  logic [31:0] inst_rdata,
  output logic        dreq,
  output logic        dwe,
  input  logic        dack,
  input  logic        alu_zero,
  input  logic        alu_lt,
  output logic [31:0] ir,
  output logic [24:0] sext_din,
  output logic [2:0]  sext_op,
  output logic [3:0]  alu_op,
  output logic        alub_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  npc_op,
  output logic        illegal,
  output logic        bus_err,
  output logic [2:0]  state_o
);

  state_e      state_q, state_nxt;
  ctrl_class_e cls;
  logic        legal;
  logic        bus_timeout;
  logic        br_taken;

  multicycle_ctrl_decode u_decode (
    .ir       (ir),
    .cls      (cls),
    .legal    (legal),
    .sext_op  (sext_op),
    .alu_op   (alu_op),
    .alub_sel (alub_sel),
    .wb_sel   (wb_sel)
  );

  assign sext_din = ir[31:7];
  assign state_o  = state_q;

  always_comb begin
    case (ir[14:12])
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_lt;
      default: br_taken = !alu_lt;
    endcase
  end

  // state register
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state_q <= S_FETCH;
    else            state_q <= state_nxt;
  end

  // instruction register and sticky illegal flag
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      ir      <= IR_NOP;
      illegal <= 1'b0;
    end else begin
      if (state_q == S_FETCH && iack) ir <= inst_rdata;
      if (state_q == S_DECODE && !legal) illegal <= 1'b1;
    end
  end

`ifdef CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] tmo_cnt;
  logic             bus_err_q;
  logic             waiting;

  assign waiting     = ((state_q == S_FETCH) && !iack) || ((state_q == S_MEM) && !dack);
  assign bus_timeout = waiting && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign bus_err     = bus_err_q;

  // wait counter restarts on every state change, counts unanswered cycles
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n)                  tmo_cnt <= '0;
    else if (state_nxt != state_q)   tmo_cnt <= '0;
    else if (waiting)                tmo_cnt <= tmo_cnt + 1'b1;
  end

  // sticky bus-timeout flag
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n)       bus_err_q <= 1'b0;
    else if (bus_timeout) bus_err_q <= 1'b1;
  end
`else
  localparam int CfgSum = TIMEOUT_CYC + CNT_W;
  logic unused_cfg;
  assign unused_cfg  = (CfgSum != 0);
  assign bus_timeout = 1'b0;
  assign bus_err     = 1'b0;
`endif

  // next-state logic
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_FETCH:  if (iack) state_nxt = S_DECODE;
                else if (bus_timeout) state_nxt = S_TRAP;
      S_DECODE: if (!legal) state_nxt = S_TRAP;
                else if (cls == CLS_LUI) state_nxt = S_WB;
                else state_nxt = S_EXEC;
      S_EXEC: begin
        case (cls)
          CLS_OP, CLS_OPIMM:    state_nxt = S_WB;
          CLS_LOAD, CLS_STORE:  state_nxt = S_MEM;
          default:              state_nxt = S_FETCH;
        endcase
      end
      S_MEM:    if (dack) state_nxt = (cls == CLS_STORE) ? S_FETCH : S_WB;
                else if (bus_timeout) state_nxt = S_TRAP;
      S_WB:     state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // strobes; held off while reset is asserted even though state reads FETCH
  always_comb begin
    ireq   = 1'b0;
    dreq   = 1'b0;
    dwe    = 1'b0;
    rf_we  = 1'b0;
    pc_we  = 1'b0;
    npc_op = NPC_PC4;
    if (cpu_rst_n) begin
      case (state_q)
        S_FETCH: ireq = 1'b1;
        S_EXEC: begin
          case (cls)
            CLS_JAL:    begin rf_we = 1'b1; pc_we = 1'b1; npc_op = NPC_JAL;  end
            CLS_JALR:   begin rf_we = 1'b1; pc_we = 1'b1; npc_op = NPC_JALR; end
            CLS_BRANCH: begin pc_we = 1'b1; npc_op = br_taken ? NPC_BR : NPC_PC4; end
            default: ;
          endcase
        end
        S_MEM: begin
          dreq = 1'b1;
          dwe  = (cls == CLS_STORE);
          if (cls == CLS_STORE) pc_we = dack;
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a table of single instructions with
// hand-computed decode outputs and retirement behaviour, then hand-written
// sequences for bus waits, traps, reset and (with CTRL_TIMEOUT_EN) timeout.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

`ifdef CTRL_TIMEOUT_EN
  localparam int TB_TMO = 8;
`else
  localparam int TB_TMO = 256;
`endif

  logic        cpu_clk, cpu_rst_n;
  logic        ireq, iack, dreq, dwe, dack, alu_zero, alu_lt;
  logic [31:0] inst_rdata, ir;
  logic [24:0] sext_din;
  logic [2:0]  sext_op, state_o;
  logic [3:0]  alu_op;
  logic        alub_sel, rf_we, pc_we, illegal, bus_err;
  logic [1:0]  wb_sel, npc_op;

  int checks, failures;

  multicycle_ctrl #(.TIMEOUT_CYC(TB_TMO), .CNT_W(9)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .ireq(ireq), .iack(iack),
    .inst_rdata(inst_rdata), .dreq(dreq), .dwe(dwe), .dack(dack),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .ir(ir), .sext_din(sext_din),
    .sext_op(sext_op), .alu_op(alu_op), .alub_sel(alub_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .pc_we(pc_we), .npc_op(npc_op), .illegal(illegal),
    .bus_err(bus_err), .state_o(state_o)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        lt;
    logic [2:0]  sext;
    logic [3:0]  alu;
    logic        alub;
    logic [1:0]  wbs;
    int          cyc;
    int          n_pc;
    int          n_rf;
    logic [1:0]  npc;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] instr, input logic zero, input logic lt,
                              input logic [2:0] sext, input logic [3:0] alu, input logic alub,
                              input logic [1:0] wbs, input int cyc, input int n_pc,
                              input int n_rf, input logic [1:0] npc, input string name);
    vec_t v;
    v.instr = instr; v.zero = zero; v.lt = lt; v.sext = sext; v.alu = alu; v.alub = alub;
    v.wbs = wbs; v.cyc = cyc; v.n_pc = n_pc; v.n_rf = n_rf; v.npc = npc; v.name = name;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic do_reset();
    cpu_rst_n = 1'b0;
    iack = 1'b0;
    dack = 1'b0;
    tick();
    tick();
    cpu_rst_n = 1'b1;
  endtask

  vec_t vecs[15];
  logic [31:0] bad[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int n, nwe, npc_cnt, nrf, quiet;
    logic [2:0] got_sext;
    logic [3:0] got_alu;
    logic       got_alub;
    logic [1:0] got_wbs, npc_seen, wbs_rf;

    checks = 0; failures = 0;
    iack = 1'b0; dack = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0; inst_rdata = '0;
    cpu_rst_n = 1'b0;

    //            instr          z     lt    sext       alu      alub  wbsel  cyc pc rf npc
    vecs[0]  = mk(32'h00500093, 1'b0, 1'b0, EXT_I,     ALU_ADD, 1'b1, WB_ALU, 4, 1, 1, NPC_PC4, "addi");
    vecs[1]  = mk(32'h123450b7, 1'b0, 1'b0, EXT_U,     ALU_ADD, 1'b1, WB_IMM, 3, 1, 1, NPC_PC4, "lui");
    vecs[2]  = mk(32'h002081b3, 1'b0, 1'b0, EXT_NONE,  ALU_ADD, 1'b0, WB_ALU, 4, 1, 1, NPC_PC4, "add");
    vecs[3]  = mk(32'h402081b3, 1'b0, 1'b0, EXT_NONE,  ALU_SUB, 1'b0, WB_ALU, 4, 1, 1, NPC_PC4, "sub");
    vecs[4]  = mk(32'h4030d093, 1'b0, 1'b0, EXT_SHIFT, ALU_SRA, 1'b1, WB_ALU, 4, 1, 1, NPC_PC4, "srai");
    vecs[5]  = mk(32'h00209093, 1'b0, 1'b0, EXT_SHIFT, ALU_SLL, 1'b1, WB_ALU, 4, 1, 1, NPC_PC4, "slli");
    vecs[6]  = mk(32'h00000463, 1'b1, 1'b0, EXT_B,     ALU_SUB, 1'b0, WB_ALU, 3, 1, 0, NPC_BR,  "beq_t");
    vecs[7]  = mk(32'h00000463, 1'b0, 1'b0, EXT_B,     ALU_SUB, 1'b0, WB_ALU, 3, 1, 0, NPC_PC4, "beq_nt");
    vecs[8]  = mk(32'h00001463, 1'b0, 1'b0, EXT_B,     ALU_SUB, 1'b0, WB_ALU, 3, 1, 0, NPC_BR,  "bne_t");
    vecs[9]  = mk(32'h00004463, 1'b0, 1'b1, EXT_B,     ALU_SUB, 1'b0, WB_ALU, 3, 1, 0, NPC_BR,  "blt_t");
    vecs[10] = mk(32'h00005463, 1'b0, 1'b1, EXT_B,     ALU_SUB, 1'b0, WB_ALU, 3, 1, 0, NPC_PC4, "bge_nt");
    vecs[11] = mk(32'h0000a103, 1'b0, 1'b0, EXT_I,     ALU_ADD, 1'b1, WB_MEM, 5, 1, 1, NPC_PC4, "lw");
    vecs[12] = mk(32'h0020a023, 1'b0, 1'b0, EXT_S,     ALU_ADD, 1'b1, WB_ALU, 4, 1, 0, NPC_PC4, "sw");
    vecs[13] = mk(32'h008000ef, 1'b0, 1'b0, EXT_J,     ALU_ADD, 1'b0, WB_PC4, 3, 1, 1, NPC_JAL, "jal");
    vecs[14] = mk(32'h000100e7, 1'b0, 1'b0, EXT_I,     ALU_ADD, 1'b1, WB_PC4, 3, 1, 1, NPC_JALR, "jalr");

    bad[0] = 32'hFFFFFFFF;   // unknown opcode
    bad[1] = 32'h00009083;   // lh: load width not supported
    bad[2] = 32'h00002463;   // branch funct3 010
    bad[3] = 32'h0000000F;   // fence

    // reset values while reset is held
    tick();
    tick();
    check("rst_ireq", 32'(ireq), 32'd0);
    check("rst_dreq", 32'(dreq), 32'd0);
    check("rst_dwe", 32'(dwe), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_ir", ir, 32'h00000013);
    check("rst_state", 32'(state_o), 32'(S_FETCH));
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk);
    check("rst_release_ireq", 32'(ireq), 32'd1);
    tick();

    // addi with iack after two wait cycles
    n = 0;
    iack = 1'b0;
    inst_rdata = 32'h00500093;
    for (int c = 0; c < 3; c++) begin
      @(negedge cpu_clk);
      if (ireq) n++;
      tick();
      iack = (c == 1);
    end
    @(negedge cpu_clk);
    check("fetch_wait_ireq_cycles", n, 3);
    check("fetch_wait_ireq_drop", 32'(ireq), 32'd0);
    check("fetch_wait_state", 32'(state_o), 32'(S_DECODE));
    check("fetch_wait_ir", ir, 32'h00500093);
    check("fetch_wait_sext", 32'(sext_op), 32'(EXT_I));
    check("fetch_wait_alub", 32'(alub_sel), 32'd1);
    check("fetch_wait_decode_pc_we", 32'(pc_we), 32'd0);
    tick();
    @(negedge cpu_clk);
    check("addi_exec_pc_we", 32'(pc_we), 32'd0);
    tick();
    @(negedge cpu_clk);
    check("addi_wb_rf_we", 32'(rf_we), 32'd1);
    check("addi_wb_wb_sel", 32'(wb_sel), 32'(WB_ALU));
    check("addi_wb_pc_we", 32'(pc_we), 32'd1);
    check("addi_wb_npc", 32'(npc_op), 32'(NPC_PC4));
    tick();
    @(negedge cpu_clk);
    check("addi_back_fetch", 32'(state_o), 32'(S_FETCH));
    tick();

    // table: one instruction each, zero-wait fetch and data bus
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      inst_rdata = v.instr; iack = 1'b1; dack = 1'b1;
      alu_zero = v.zero; alu_lt = v.lt;
      npc_cnt = 0; nrf = 0;
      got_sext = 'x; got_alu = 'x; got_alub = 'x; got_wbs = 'x; npc_seen = 'x; wbs_rf = 'x;
      for (int c = 0; c < v.cyc; c++) begin
        @(negedge cpu_clk);
        if (state_o == S_DECODE) begin
          got_sext = sext_op; got_alu = alu_op; got_alub = alub_sel; got_wbs = wb_sel;
        end
        if (pc_we) begin npc_cnt++; npc_seen = npc_op; end
        if (rf_we) begin nrf++; wbs_rf = wb_sel; end
        tick();
        iack = 1'b0;
      end
      @(negedge cpu_clk);
      check({v.name, "_sext"}, 32'(got_sext), 32'(v.sext));
      check({v.name, "_alu"}, 32'(got_alu), 32'(v.alu));
      check({v.name, "_alub"}, 32'(got_alub), 32'(v.alub));
      check({v.name, "_wbsel"}, 32'(got_wbs), 32'(v.wbs));
      check({v.name, "_pc_we_count"}, npc_cnt, v.n_pc);
      check({v.name, "_rf_we_count"}, nrf, v.n_rf);
      check({v.name, "_npc"}, 32'(npc_seen), 32'(v.npc));
      if (v.n_rf != 0) check({v.name, "_wbsel_at_rf"}, 32'(wbs_rf), 32'(v.wbs));
      check({v.name, "_end_state"}, 32'(state_o), 32'(S_FETCH));
      check({v.name, "_end_ireq"}, 32'(ireq), 32'd1);
      dack = 1'b0;
      tick();
    end
    alu_zero = 1'b0; alu_lt = 1'b0;

    // lw with dack after three wait cycles in MEM
    inst_rdata = 32'h0000a103; iack = 1'b1; dack = 1'b0;
    tick(); iack = 1'b0;
    tick();
    tick();
    n = 0; nwe = 0; npc_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge cpu_clk);
      if (dreq) n++;
      if (dwe) nwe++;
      if (pc_we) npc_cnt++;
      tick();
      dack = (c == 2);
    end
    @(negedge cpu_clk);
    check("lw_dreq_cycles", n, 4);
    check("lw_dwe_cycles", nwe, 0);
    check("lw_mem_pc_we", npc_cnt, 0);
    check("lw_wb_state", 32'(state_o), 32'(S_WB));
    check("lw_wb_rf_we", 32'(rf_we), 32'd1);
    check("lw_wb_wb_sel", 32'(wb_sel), 32'(WB_MEM));
    check("lw_wb_dreq", 32'(dreq), 32'd0);
    tick();

    // sw with one wait cycle: pc_we only on the dack cycle
    inst_rdata = 32'h0020a023; iack = 1'b1; dack = 1'b0;
    tick(); iack = 1'b0;
    tick();
    tick();
    @(negedge cpu_clk);
    check("sw_dreq", 32'(dreq), 32'd1);
    check("sw_dwe", 32'(dwe), 32'd1);
    check("sw_sext", 32'(sext_op), 32'(EXT_S));
    check("sw_wait_pc_we", 32'(pc_we), 32'd0);
    tick();
    dack = 1'b1;
    @(negedge cpu_clk);
    check("sw_ack_pc_we", 32'(pc_we), 32'd1);
    check("sw_ack_npc", 32'(npc_op), 32'(NPC_PC4));
    check("sw_ack_rf_we", 32'(rf_we), 32'd0);
    tick();
    dack = 1'b0;
    @(negedge cpu_clk);
    check("sw_end_state", 32'(state_o), 32'(S_FETCH));
    check("sw_end_dreq", 32'(dreq), 32'd0);
    tick();

    // illegal encodings trap and stay quiet until reset
    for (int k = 0; k < 4; k++) begin
      inst_rdata = bad[k]; iack = 1'b1;
      tick(); iack = 1'b0;
      tick();
      quiet = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge cpu_clk);
        if (ireq || dreq || pc_we || rf_we) quiet++;
        tick();
      end
      check($sformatf("trap%0d_state", k), 32'(state_o), 32'(S_TRAP));
      check($sformatf("trap%0d_illegal", k), 32'(illegal), 32'd1);
      check($sformatf("trap%0d_strobes", k), quiet, 0);
      cpu_rst_n = 1'b0;
      #2;
      check($sformatf("trap%0d_rst_illegal", k), 32'(illegal), 32'd0);
      check($sformatf("trap%0d_rst_state", k), 32'(state_o), 32'(S_FETCH));
      do_reset();
      @(negedge cpu_clk);
      check($sformatf("trap%0d_ireq_after_rst", k), 32'(ireq), 32'd1);
      tick();
    end

    // reset asserted in the middle of a MEM wait, then iack during reset
    inst_rdata = 32'h0000a103; iack = 1'b1; dack = 1'b0;
    tick(); iack = 1'b0;
    tick();
    tick();
    @(negedge cpu_clk);
    check("midmem_dreq", 32'(dreq), 32'd1);
    #2;
    cpu_rst_n = 1'b0;
    #1;
    check("midmem_rst_dreq", 32'(dreq), 32'd0);
    check("midmem_rst_ir", ir, 32'h00000013);
    check("midmem_rst_state", 32'(state_o), 32'(S_FETCH));
    check("midmem_rst_ireq", 32'(ireq), 32'd0);
    inst_rdata = 32'hDEADBEEF; iack = 1'b1;
    tick();
    check("rst_iack_ir", ir, 32'h00000013);
    check("rst_iack_ireq", 32'(ireq), 32'd0);
    cpu_rst_n = 1'b1; iack = 1'b0;
    @(negedge cpu_clk);
    check("rst_iack_release_ireq", 32'(ireq), 32'd1);
    tick();

    // fetch with no iack
    do_reset();
    n = 0;
`ifdef CTRL_TIMEOUT_EN
    for (int c = 0; c < 12; c++) begin
      @(negedge cpu_clk);
      if (ireq) n++;
      tick();
    end
    check("tmo_ireq_cycles", n, 8);
    check("tmo_bus_err", 32'(bus_err), 32'd1);
    check("tmo_state", 32'(state_o), 32'(S_TRAP));
    check("tmo_ireq", 32'(ireq), 32'd0);
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge cpu_clk);
      if (ireq) n++;
      tick();
    end
    check("nowait_ireq_cycles", n, 20);
    check("nowait_bus_err", 32'(bus_err), 32'd0);
    check("nowait_state", 32'(state_o), 32'(S_FETCH));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
